mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 32, width of all data ports.
REQ-003 Parameter MAX_D_BURST, default 4, maximum consecutive data grants while a fetch waits; legal range 1..15.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction fetch request; level, held until if_valid.
REQ-007 if_addr  input  ADDR_W  fetch address; stable while if_req high.
REQ-008 if_flush  input  1  cancels pending or in-flight fetch (branch taken).
REQ-009 if_rdata  output  DATA_W  fetched word; meaningful only when if_valid high.
REQ-010 if_valid  output  1  one-cycle pulse, fetch complete.
REQ-011 d_req  input  1  data request; level, held until d_valid.
REQ-012 d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_rdata  output  DATA_W  load data; meaningful only when d_valid high.
REQ-016 d_valid  output  1  one-cycle pulse, data access complete (loads and stores).
REQ-017 mem_req  output  1  request to single-port memory; registered.
REQ-018 mem_we  output  1  write enable to memory; registered.
REQ-019 mem_addr  output  ADDR_W  memory address; registered.
REQ-020 mem_wdata  output  DATA_W  memory write data; registered.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-022 mem_ack  input  1  memory completion, one cycle, any latency >= 1 cycle after mem_req rises.

Function
REQ-023 States: IDLE, IF_BUSY, D_BUSY, IF_DROP; encoding free.
REQ-024 IDLE: at clock edge with d_req high and starvation counter < MAX_D_BURST -> D_BUSY; else if if_req high and if_flush low -> IF_BUSY; else stay IDLE.
REQ-025 On entry to IF_BUSY/D_BUSY: mem_req=1, mem_addr/mem_we/mem_wdata latched from granted port (mem_we=0, mem_wdata unchanged for fetch); all held constant until mem_ack.
REQ-026 IF_BUSY/D_BUSY with mem_ack high at edge -> IDLE; mem_req=0; granted port's rdata registered from mem_rdata and its valid pulses high for exactly the next cycle.
REQ-027 Minimum transaction: request sampled edge 0, mem_req high cycle 1, ack cycle 1 -> valid in cycle 2; next grant sampled at end of cycle 2.
REQ-028 A req still high during its own valid cycle is a new request, sampled that cycle in IDLE.
REQ-029 Starvation counter (4 bits): increments on each D grant made while if_req high and if_flush low; clears on IF grant or when if_req low in IDLE; counter == MAX_D_BURST forces IF grant over d_req.
REQ-030 if_flush in IDLE: fetch not granted that edge. if_flush in IF_BUSY before/with ack -> IF_DROP (or IDLE if ack same edge); memory transaction completes, if_valid suppressed, if_rdata unchanged.
REQ-031 IF_DROP: mem_req held; on mem_ack -> IDLE, no valid pulse.
REQ-032 if_flush has no effect on a data transaction.
REQ-033 if_valid and d_valid never high in the same cycle.
REQ-034 mem_ack while mem_req low is ignored.

Reset
REQ-035 reset low asynchronously forces IDLE, counter 0, mem_req 0, mem_we 0, if_valid 0, d_valid 0, mem_addr/mem_wdata/if_rdata/d_rdata 0.
REQ-036 Reset mid-transaction abandons it; no valid pulse after release; first grant no earlier than first edge with reset high.

Verification
REQ-037 Fetch only, if_addr=0x100, ack 3 cycles after mem_req -> mem_addr=0x100, mem_we=0, if_valid one cycle with if_rdata=mem_rdata, one cycle after ack.
REQ-038 if_req and d_req (store, addr 0x200, data 0xDEADBEEF) same edge -> data first, mem_we=1, d_valid; then fetch granted.
REQ-039 d_req held continuously with if_req high, MAX_D_BURST=4 -> exactly 4 data grants, then 1 fetch grant, counter back to 0.
REQ-040 if_flush asserted one cycle after fetch grant, ack 2 cycles later -> mem_req held until ack, no if_valid, returns to IDLE.
REQ-041 reset low during D_BUSY -> mem_req=0 and d_valid=0 immediately; after release, pending d_req granted afresh.
REQ-042 Zero-wait memory (ack in first mem_req cycle), alternating requests -> one transaction per 2 cycles, valid pulses never overlap.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one single-port memory between an instruction-fetch port and
//   a data (load/store) port. Data requests win in IDLE unless the fetch side
//   has been passed over MAX_D_BURST times in a row, at which point the fetch
//   is granted. A fetch can be cancelled by if_flush; the memory transaction
//   still runs to completion but its result is discarded.
//
// Ports
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   if_req/if_addr    : fetch request (level) and address
//   if_flush          : cancel pending / in-flight fetch
//   if_rdata/if_valid : fetch result, valid for one cycle
//   d_req/d_we        : data request (level), 1 = store
//   d_addr/d_wdata    : data address and store data
//   d_rdata/d_valid   : load result / access complete, one-cycle pulse
//   mem_req/mem_we    : registered memory request and write enable
//   mem_addr/mem_wdata: registered memory address and write data
//   mem_rdata/mem_ack : memory read data and one-cycle completion
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    IF_DROP = 2'd3
  } state_t;

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_D_BURST);

  state_t            r_state;
  logic [3:0]        r_starve;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_valid;

  logic              w_idle;
  logic              w_fetch_live;
  logic              w_grant_d;
  logic              w_grant_if;
  logic [3:0]        w_starve_nxt;

  // A fetch only competes when it is not being cancelled this cycle.
  assign w_idle       = (r_state == IDLE);
  assign w_fetch_live = if_req && !if_flush;
  assign w_grant_d    = w_idle && d_req && (r_starve < LP_MAX_BURST);
  assign w_grant_if   = w_idle && !w_grant_d && w_fetch_live;

  // Starvation counter: counts data grants that bypassed a live fetch.
  // It can never pass LP_MAX_BURST because data is not granted at the limit.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_idle) begin
      if (!if_req) begin
        w_starve_nxt = '0;
      end else if (w_grant_if) begin
        w_starve_nxt = '0;
      end else if (w_grant_d && !if_flush) begin
        w_starve_nxt = r_starve + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_starve   <= w_starve_nxt;
      unique case (r_state)
        IDLE: begin
          // mem_ack is ignored here: no transaction is outstanding.
          if (w_grant_d) begin
            r_state     <= D_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (w_grant_if) begin
            r_state    <= IF_BUSY;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            // A flush coinciding with the ack discards the result.
            if (!if_flush) begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end
          end else if (if_flush) begin
            r_state <= IF_DROP;
          end
        end
        D_BUSY: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_d_rdata <= mem_rdata;
            r_d_valid <= 1'b1;
          end
        end
        IF_DROP: begin
          // Memory cannot be aborted; wait out the ack silently.
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int unsigned n_chk;
  int unsigned n_err;
  int unsigned lat;
  logic        stray;
  int unsigned wcnt;
  logic        ack_done;
  int unsigned overlap;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_BURST(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_flush(if_flush),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: acks in the lat-th cycle of mem_req (lat=1 is zero-wait),
  // read data = address ^ 0x5A5A0000. stray drives an ack with no request.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wcnt      = 0;
    ack_done  = 1'b0;
  end
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (!mem_req) begin
      wcnt     = 0;
      ack_done = 1'b0;
      if (stray) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end else if (!ack_done) begin
      wcnt = wcnt + 1;
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ 32'h5A5A_0000;
        ack_done  = 1'b1;
      end
    end
  end

  initial overlap = 0;
  always @(negedge clock) begin
    if (if_valid && d_valid) overlap = overlap + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       found;
    int         ncyc;
    logic [31:0] exp_addr;

    n_chk    = 0;
    n_err    = 0;
    lat      = 1;
    stray    = 1'b0;
    reset    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;

    // Reset state
    tick;
    chk1 ("rst_mem_req",   mem_req,   1'b0);
    chk1 ("rst_mem_we",    mem_we,    1'b0);
    chk32("rst_mem_addr",  mem_addr,  32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_if_rdata",  if_rdata,  32'h0);
    chk32("rst_d_rdata",   d_rdata,   32'h0);
    chk1 ("rst_if_valid",  if_valid,  1'b0);
    chk1 ("rst_d_valid",   d_valid,   1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Fetch only, ack in the third mem_req cycle
    lat = 3; if_req = 1'b1; if_addr = 32'h100;
    tick;
    chk1 ("f1_req",   mem_req,  1'b1);
    chk32("f1_addr",  mem_addr, 32'h100);
    chk1 ("f1_we",    mem_we,   1'b0);
    tick;
    chk1 ("f1_hold1", mem_req,  1'b1);
    chk1 ("f1_nov1",  if_valid, 1'b0);
    tick;
    chk1 ("f1_hold2", mem_req,  1'b1);
    chk1 ("f1_nov2",  if_valid, 1'b0);
    tick;
    chk1 ("f1_valid", if_valid, 1'b1);
    chk32("f1_rdata", if_rdata, 32'h5A5A_0100);
    chk1 ("f1_reqlo", mem_req,  1'b0);
    chk1 ("f1_dv",    d_valid,  1'b0);
    if_req = 1'b0;
    tick;
    chk1 ("f1_pulse", if_valid, 1'b0);
    chk1 ("f1_idle",  mem_req,  1'b0);

    // Simultaneous store and fetch: data first, then fetch
    lat = 1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h104;
    tick;
    chk1 ("s_req",   mem_req,   1'b1);
    chk1 ("s_we",    mem_we,    1'b1);
    chk32("s_addr",  mem_addr,  32'h200);
    chk32("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick;
    chk1 ("s_dv",    d_valid,   1'b1);
    chk1 ("s_ifv",   if_valid,  1'b0);
    chk1 ("s_reqlo", mem_req,   1'b0);
    d_req = 1'b0; d_we = 1'b0;
    tick;
    chk1 ("s_f_req",   mem_req,   1'b1);
    chk32("s_f_addr",  mem_addr,  32'h104);
    chk1 ("s_f_we",    mem_we,    1'b0);
    chk32("s_f_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick;
    chk1 ("s_f_valid", if_valid,  1'b1);
    chk32("s_f_rdata", if_rdata,  32'h5A5A_0104);
    if_req = 1'b0;
    tick;
    chk1 ("s_f_pulse", if_valid,  1'b0);

    // Starvation: both held, pattern D D D D I repeated twice
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h108;
    for (int g = 0; g < 10; g++) begin
      tick;
      exp_addr = ((g % 5) == 4) ? 32'h108 : 32'h300;
      chk1 ("sv_req",  mem_req,  1'b1);
      chk32("sv_addr", mem_addr, exp_addr);
      tick;
      if ((g % 5) == 4) begin
        chk1 ("sv_ifv",   if_valid, 1'b1);
        chk1 ("sv_ifv_d", d_valid,  1'b0);
      end else begin
        chk1 ("sv_dv",    d_valid,  1'b1);
        chk1 ("sv_dv_i",  if_valid, 1'b0);
        chk32("sv_drd",   d_rdata,  32'h5A5A_0300);
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    tick;
    chk1 ("sv_idle", mem_req, 1'b0);

    // Flush one cycle after fetch grant, ack two cycles later
    lat = 3; if_req = 1'b1; if_addr = 32'h10C;
    tick;
    chk1 ("fl_req",   mem_req,  1'b1);
    chk32("fl_addr",  mem_addr, 32'h10C);
    if_flush = 1'b1;
    tick;
    chk1 ("fl_hold1", mem_req,  1'b1);
    if_flush = 1'b0; if_req = 1'b0;
    tick;
    chk1 ("fl_hold2", mem_req,  1'b1);
    chk1 ("fl_nov2",  if_valid, 1'b0);
    tick;
    chk1 ("fl_reqlo", mem_req,  1'b0);
    chk1 ("fl_nov3",  if_valid, 1'b0);
    tick;
    chk1 ("fl_nov4",  if_valid, 1'b0);
    chk1 ("fl_idle",  mem_req,  1'b0);
    chk32("fl_rdata", if_rdata, 32'h5A5A_0108);

    // Flush in IDLE blocks the grant for that edge
    lat = 1; if_req = 1'b1; if_addr = 32'h110; if_flush = 1'b1;
    tick;
    chk1 ("fi_nogrant", mem_req, 1'b0);
    if_flush = 1'b0;
    tick;
    chk1 ("fi_req",   mem_req,  1'b1);
    chk32("fi_addr",  mem_addr, 32'h110);
    tick;
    chk1 ("fi_valid", if_valid, 1'b1);
    chk32("fi_rdata", if_rdata, 32'h5A5A_0110);
    if_req = 1'b0;
    tick;

    // Flush on the same edge as ack
    lat = 2; if_req = 1'b1; if_addr = 32'h114;
    tick;
    chk1 ("fa_req", mem_req, 1'b1);
    tick;
    if_flush = 1'b1;
    tick;
    chk1 ("fa_reqlo", mem_req,  1'b0);
    chk1 ("fa_nov",   if_valid, 1'b0);
    if_flush = 1'b0; if_req = 1'b0;
    tick;
    chk1 ("fa_nov2",  if_valid, 1'b0);
    chk32("fa_rdata", if_rdata, 32'h5A5A_0110);

    // Flush has no effect on a data load
    lat = 2; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; if_flush = 1'b1;
    tick;
    chk1 ("dfl_req",  mem_req,  1'b1);
    chk32("dfl_addr", mem_addr, 32'h204);
    tick;
    chk1 ("dfl_nov",  d_valid,  1'b0);
    tick;
    chk1 ("dfl_dv",   d_valid,  1'b1);
    chk32("dfl_rd",   d_rdata,  32'h5A5A_0204);
    d_req = 1'b0; if_flush = 1'b0;
    tick;

    // Reset during D_BUSY, then fresh grant
    lat = 5; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h208; d_wdata = 32'h1234_5678;
    tick;
    chk1 ("rd_req", mem_req, 1'b1);
    tick;
    #2;
    reset = 1'b0;
    #1;
    chk1 ("rd_reqlo", mem_req,   1'b0);
    chk1 ("rd_dv",    d_valid,   1'b0);
    chk1 ("rd_we",    mem_we,    1'b0);
    chk32("rd_addr",  mem_addr,  32'h0);
    chk32("rd_wdata", mem_wdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick;
    chk1 ("rg_req",   mem_req,   1'b1);
    chk1 ("rg_we",    mem_we,    1'b1);
    chk32("rg_addr",  mem_addr,  32'h208);
    chk32("rg_wdata", mem_wdata, 32'h1234_5678);
    chk1 ("rg_nodv",  d_valid,   1'b0);
    found = 1'b0;
    ncyc  = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick;
      ncyc++;
      if (d_valid) found = 1'b1;
    end
    chk1 ("rg_valid_seen", found, 1'b1);
    chk32("rg_latency", 32'(ncyc), 32'd5);
    d_req = 1'b0; d_we = 1'b0;
    tick;

    // Ack without a request is ignored
    stray = 1'b1;
    tick;
    stray = 1'b0;
    chk1 ("st_ifv", if_valid, 1'b0);
    chk1 ("st_dv",  d_valid,  1'b0);
    chk1 ("st_req", mem_req,  1'b0);
    tick;
    chk1 ("st_ifv2", if_valid, 1'b0);
    chk1 ("st_dv2",  d_valid,  1'b0);

    // Zero-wait memory, alternating fetch/load: one transaction per 2 cycles
    lat = 1; if_req = 1'b1; if_addr = 32'h118; d_addr = 32'h20C; d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      exp_addr = ((k % 2) == 0) ? 32'h118 : 32'h20C;
      chk1 ("alt_req",  mem_req,  1'b1);
      chk32("alt_addr", mem_addr, exp_addr);
      tick;
      chk1 ("alt_ifv", if_valid, ((k % 2) == 0));
      chk1 ("alt_dv",  d_valid,  ((k % 2) == 1));
      if ((k % 2) == 0) begin
        if_req = 1'b0; d_req = (k < 5);
      end else begin
        d_req = 1'b0; if_req = (k < 5);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick;
    chk1 ("alt_idle", mem_req, 1'b0);

    chk32("no_overlap", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
